// File: rtl/fibo_scheduler.sv
// Round-robin front end that time-shares one fibonacci_calculator among N_REQ requesters,
// sequencing clear/settle/start/wait on the calculator and routing the result back to the job owner.
module fibo_scheduler #(
  parameter int N_REQ     = 4,
  parameter int TIMEOUT   = 1023,
  parameter int MAX_INDEX = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [5*N_REQ-1:0] req_index,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [15:0]        rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic               calc_reset_n,
  output logic [4:0]         calc_input_s,
  output logic               calc_begin,
  input  logic [15:0]        calc_fibo_out,
  input  logic               calc_done,
  output logic [2:0]         dbg_state
);

  // Handshake: requester i holds req[i] high with req_index stable until a single-cycle
  // rsp_valid[i] pulse; rsp_data/rsp_err are meaningful only in that cycle. A job, once
  // granted, always completes even if req[i] falls; only reset aborts it.

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [4:0]     MAX_IDX   = 5'(MAX_INDEX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [4:0]       r_index;
  logic             r_phase;
  logic [WCW-1:0]   r_wait_cnt;

  logic             w_any;
  logic [2:0]       w_gnt;
  logic [4:0]       w_gnt_idx;
  logic [3:0]       w_off;
  logic [3:0]       w_best;
  logic [N_REQ-1:0] w_gnt_1h;
  logic [N_REQ-1:0] w_own_1h;
  logic [2:0]       w_next_ptr;

  // Pick the requester with the smallest circular distance from the pointer.
  always_comb begin
    w_any     = 1'b0;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_off     = '0;
    w_best    = 4'hf;
    for (int i = 0; i < N_REQ; i++) begin
      if (4'(i) >= {1'b0, r_ptr}) w_off = 4'(i) - {1'b0, r_ptr};
      else                        w_off = 4'(i) + 4'(N_REQ) - {1'b0, r_ptr};
      if (req[i] && (w_off < w_best)) begin
        w_best    = w_off;
        w_any     = 1'b1;
        w_gnt     = 3'(i);
        w_gnt_idx = req_index[5*i +: 5];
      end
    end
  end

  always_comb begin
    w_gnt_1h = '0;
    w_own_1h = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_gnt_1h[i] = w_any && (w_gnt == 3'(i));
      w_own_1h[i] = (grant_id == 3'(i));
    end
  end

  assign w_next_ptr = (w_gnt == 3'(N_REQ - 1)) ? 3'd0 : w_gnt + 3'd1;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_index      <= '0;
      r_phase      <= 1'b0;
      r_wait_cnt   <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= '0;
      calc_reset_n <= 1'b0;
      calc_input_s <= '0;
      calc_begin   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant_id <= w_gnt;
            r_ptr    <= w_next_ptr;
            r_index  <= w_gnt_idx;
            busy     <= 1'b1;
            r_phase  <= 1'b0;
            if (w_gnt_idx > MAX_IDX) begin
              // Result would overflow 16 bits: answer at once, calculator untouched.
              r_state   <= S_RESP;
              rsp_valid <= w_gnt_1h;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
            end else begin
              r_state      <= S_CLR;
              calc_reset_n <= 1'b0;
            end
          end
        end
        S_CLR: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_state      <= S_SETTLE;
            calc_reset_n <= 1'b1;
          end
        end
        S_SETTLE: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_state      <= S_START;
            calc_begin   <= 1'b1;
            calc_input_s <= r_index;
          end
        end
        S_START: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_state    <= S_WAIT;
            calc_begin <= 1'b0;
            r_wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (calc_done) begin
            r_state      <= S_RESP;
            rsp_valid    <= w_own_1h;
            rsp_data     <= calc_fibo_out;
            rsp_err      <= 1'b0;
            calc_input_s <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state      <= S_RESP;
            rsp_valid    <= w_own_1h;
            rsp_data     <= '0;
            rsp_err      <= 1'b1;
            calc_input_s <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state   <= S_DRAIN;
          rsp_valid <= '0;
          rsp_data  <= '0;
          rsp_err   <= 1'b0;
        end
        S_DRAIN: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_scheduler.sv
// Bench for fibo_scheduler: calculator stub, requester drivers, and a round-robin
// reference model feeding an expected-response queue.
module tb_fibo_scheduler;

  localparam int N    = 4;
  localparam int TMO  = 16;
  localparam int MAXI = 24;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [5*N-1:0]   req_index;
  logic [N-1:0]     rsp_valid;
  logic [15:0]      rsp_data;
  logic             rsp_err;
  logic             busy;
  logic [2:0]       grant_id;
  logic             calc_reset_n;
  logic [4:0]       calc_input_s;
  logic             calc_begin;
  logic [15:0]      calc_fibo_out;
  logic             calc_done;
  logic [2:0]       dbg_state;

  fibo_scheduler #(.N_REQ(N), .TIMEOUT(TMO), .MAX_INDEX(MAXI)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .grant_id(grant_id), .calc_reset_n(calc_reset_n), .calc_input_s(calc_input_s),
    .calc_begin(calc_begin), .calc_fibo_out(calc_fibo_out), .calc_done(calc_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // expected entry: {owner[31:29], err[28], data[27:12], latency[11:4], clr_cycles[3:2], begin_cycles[1:0]}
  logic [31:0] exp_q[$];
  int          m_ptr = 0;
  int          m_idx[N];

  // calculator stub
  bit          stub_armed = 0;
  bit          stub_stuck = 0;
  int          stub_delay = 0;
  int          stub_cnt   = 0;
  int          stub_idx   = 0;

  // per-job observations
  bit          prev_busy = 0;
  int          rise_cyc  = 0;
  int          job_clr   = 0;
  int          job_beg   = 0;
  bit          hold      = 0;
  int          hold_n    = 0;
  int          resp_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] fib(input int n);
    int a = 0;
    int b = 1;
    int t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return 16'(a);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] make_exp(input int owner, input int idx, input int d, input bit stuck);
    logic [31:0] e;
    if (idx > MAXI)  e = {3'(owner), 1'b1, 16'd0, 8'd0, 2'd0, 2'd0};
    else if (stuck)  e = {3'(owner), 1'b1, 16'd0, 8'(6 + TMO), 2'd2, 2'd2};
    else             e = {3'(owner), 1'b0, fib(idx), 8'(8 + d), 2'd2, 2'd2};
    return e;
  endfunction

  task automatic model_run(input logic [N-1:0] mask_in, input int n, input bit hold_mode,
                           input int d, input bit stuck);
    logic [N-1:0] mask;
    int pick;
    bit found;
    mask = mask_in;
    for (int k = 0; k < n; k++) begin
      found = 0;
      pick  = 0;
      for (int j = 0; j < N; j++) begin
        if (!found && mask[(m_ptr + j) % N]) begin
          found = 1;
          pick  = (m_ptr + j) % N;
        end
      end
      m_ptr = (pick + 1) % N;
      if (!hold_mode) mask[pick] = 1'b0;
      exp_q.push_back(make_exp(pick, m_idx[pick], d, stuck));
    end
  endtask

  // ---------------- driver / monitor ----------------
  task automatic issue(input int i, input int idx);
    req_index[5*i +: 5] = 5'(idx);
    req[i]              = 1'b1;
    m_idx[i]            = idx;
  endtask

  task automatic tick();
    logic [31:0] e;
    int owner;
    @(negedge clk);
    cyc++;
    if (!calc_reset_n) begin
      calc_done     = 1'b0;
      calc_fibo_out = '0;
      stub_armed    = 0;
    end else if (calc_begin) begin
      stub_armed = 1;
      stub_idx   = int'(calc_input_s);
      stub_cnt   = stub_delay + 1;
    end else if (stub_armed && !stub_stuck) begin
      if (stub_cnt == 0) begin
        calc_done     = 1'b1;
        calc_fibo_out = fib(stub_idx);
      end else begin
        stub_cnt--;
      end
    end
    if (busy && !prev_busy) begin
      rise_cyc = cyc;
      job_clr  = 0;
      job_beg  = 0;
    end
    prev_busy = busy;
    if (busy && !calc_reset_n) job_clr++;
    if (calc_begin) job_beg++;
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e     = exp_q.pop_front();
        owner = int'(e[31:29]);
        chk("rsp_owner", 32'(rsp_valid), 32'(1 << owner));
        chk("grant_id", 32'(grant_id), 32'(owner));
        chk("rsp_err", 32'(rsp_err), 32'(e[28]));
        chk("rsp_data", 32'(rsp_data), 32'(e[27:12]));
        chk("latency", 32'(cyc - rise_cyc), 32'(e[11:4]));
        chk("clr_cycles", 32'(job_clr), 32'(e[3:2]));
        chk("begin_cycles", 32'(job_beg), 32'(e[1:0]));
      end
      resp_cnt++;
      if (hold) begin
        if (resp_cnt == hold_n) req = '0;
      end else begin
        req = req & ~rsp_valid;
      end
    end else if (rsp_err || rsp_data != '0) begin
      chk("rsp_quiet", {15'd0, rsp_err, rsp_data}, 32'd0);
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((exp_q.size() != 0 || busy) && b < 2000) begin
      tick();
      b++;
    end
    if (b >= 2000) chk("wait_budget", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_calc_reset_n"}, 32'(calc_reset_n), 32'd0);
    chk({tag, "_calc_input_s"}, 32'(calc_input_s), 32'd0);
    chk({tag, "_calc_begin"}, 32'(calc_begin), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] mask;
    int n;
    int b;
    reset_n       = 1'b0;
    req           = '0;
    req_index     = '0;
    calc_done     = 1'b0;
    calc_fibo_out = '0;
    for (int i = 0; i < N; i++) m_idx[i] = 0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // two simultaneous requesters from pointer 0: 0 first, then 2
    stub_delay = 2;
    issue(0, 9);
    issue(2, 12);
    model_run(4'b0101, 2, 0, stub_delay, 0);
    wait_idle();

    // single job, fastest calculator
    stub_delay = 0;
    issue(0, 5);
    model_run(4'b0001, 1, 0, stub_delay, 0);
    wait_idle();

    // fairness: everyone holds req for five grants
    hold     = 1;
    hold_n   = 5;
    resp_cnt = 0;
    for (int i = 0; i < N; i++) issue(i, 1);
    model_run(4'b1111, 5, 1, stub_delay, 0);
    wait_idle();
    hold = 0;

    // out-of-range index bypasses the calculator
    issue(1, 25);
    model_run(4'b0010, 1, 0, stub_delay, 0);
    wait_idle();
    issue(1, 24);
    model_run(4'b0010, 1, 0, stub_delay, 0);
    wait_idle();

    // calculator never finishes, then a normal job
    stub_stuck = 1;
    issue(3, 10);
    model_run(4'b1000, 1, 0, stub_delay, 1);
    wait_idle();
    stub_stuck = 0;
    issue(3, 10);
    model_run(4'b1000, 1, 0, stub_delay, 0);
    wait_idle();

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      mask = 4'($urandom_range(1, 15));
      stub_delay = $urandom_range(0, 8);
      n = 0;
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          issue(i, $urandom_range(0, 27));
          n++;
        end
      end
      model_run(mask, n, 0, stub_delay, 0);
      wait_idle();
    end

    // reset during WAIT aborts the job and rewinds the pointer
    stub_delay = 8;
    issue(2, 12);
    model_run(4'b0100, 1, 0, stub_delay, 0);
    b = 0;
    while (!busy && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) chk("mid_reset_grant", 32'(busy), 32'd1);
    repeat (8) tick();
    exp_q.delete();
    m_ptr = 0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    req = '0;
    repeat (4) tick();
    reset_n = 1'b1;
    tick();
    stub_delay = 1;
    issue(2, 12);
    issue(3, 7);
    model_run(4'b1100, 2, 0, stub_delay, 0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fibo_scheduler.md
# fibo_scheduler

Round-robin scheduler that shares one `fibonacci_calculator` among `N_REQ` requesters. It sequences each job through the calculator's clear, start and wait protocol, then returns the 16-bit result to the requester that owns the job. Indices whose result cannot fit in 16 bits are rejected without using the calculator. The block sits between the requesting engines and the single calculator instance, and owns that instance's reset, start and input pins.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 1023: maximum WAIT cycles before a job is aborted with an error.
- `MAX_INDEX`, default 24: largest accepted index. F(24)=46368 is the last value that fits in 16 bits.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester request level.
- `req_index` in 5*N_REQ: packed indices. Requester i uses bits [5i+4:5i].
- `rsp_valid` out N_REQ: one-cycle response pulse for the owning requester.
- `rsp_data` out 16: result, shared by all requesters, valid only while any `rsp_valid` bit is high.
- `rsp_err` out 1: error flag, qualified by `rsp_valid`.
- `busy` out 1: high whenever the state is not IDLE.
- `grant_id` out 3: requester that owns the current job.
- `calc_reset_n` out 1: drives the calculator's `reset_n`.
- `calc_input_s` out 5: drives the calculator's `input_s`.
- `calc_begin` out 1: drives the calculator's `begin_fibo`.
- `calc_fibo_out` in 16: calculator result.
- `calc_done` in 1: calculator completion flag.

## Operation
- **Reset values.** All outputs are 0, including `calc_reset_n`, so the calculator is held in reset. The round-robin pointer is 0, which makes requester 0 the highest priority.
- **Requester contract.** A requester holds `req` high and `req_index` stable until its `rsp_valid` pulse. It drops `req` in the following cycle.
- **Dropped requests.** If a requester drops `req` mid-job, the job still completes and the response is still pulsed.
- **IDLE.** If any `req` bit is high, grant the first requesting index at or after the pointer, wrapping modulo N_REQ. On that edge:
  - register the index and `grant_id`;
  - set the pointer to `grant_id+1`, modulo N_REQ.
  - If the index is greater than MAX_INDEX, go to RESP with the error set. Otherwise go to CLR.
- **CLR** (2 cycles): `calc_reset_n`=0.
- **SETTLE** (2 cycles): `calc_reset_n`=1 and `calc_begin`=0.
- **START** (2 cycles): `calc_begin`=1 and `calc_input_s`=index.
- **WAIT:**
  - `calc_begin`=0, and `calc_input_s` is held at the index.
  - When `calc_done` is sampled 1, capture `calc_fibo_out` into the result register and go to RESP.
  - Otherwise increment the wait counter. If it reaches TIMEOUT, go to RESP with the error set and data 0.
- **RESP** (1 cycle):
  - `rsp_valid[grant_id]`=1 and `rsp_data` = the result.
  - `rsp_err` = the error flag.
  - Go to DRAIN.
- **DRAIN** (1 cycle): no arbitration, which lets the served requester drop `req`. Then go to IDLE.
- **Output behaviour outside RESP.** `rsp_data` and `rsp_err` return to 0. `calc_reset_n` remains 1 in IDLE, DRAIN and RESP once the first job has run.
- **Arithmetic.** The calculator follows F(0)=0, F(1)=1. `rsp_data` is passed through unmodified. The wait counter is 10 bits wide, sized by TIMEOUT.

## Timing
- Latency is counted from the grant edge, cycle 0:
  - CLR occupies cycles 1–2, SETTLE cycles 3–4 and START cycles 5–6.
  - WAIT starts at cycle 7.
  - RESP is the cycle after `calc_done` is first sampled high.
  - Minimum end-to-end latency is 9 cycles from the grant edge to `rsp_valid`.
- An out-of-range index reaches RESP in the cycle after the grant edge.
- Back-to-back jobs: the next grant is at the earliest in the IDLE cycle after DRAIN, which is 3 cycles after RESP.
- **Simultaneous requests.** Exactly one grant per IDLE visit, in round-robin order. A requester that is re-requesting and sits at the pointer position wins over all others.
- **`calc_done` stuck high.** A stale `calc_done` from a previous job cannot be seen, because CLR clears the calculator and WAIT begins after START.
- **Reset mid-operation.** The job is aborted immediately and asynchronously:
  - no `rsp_valid` pulse is produced;
  - outputs return to their reset values;
  - the pointer returns to 0.

## Test plan
- **Single job.** Requester 0 sends index 5 → `rsp_valid[0]` pulses once, `rsp_data`=5, `rsp_err`=0. `calc_begin` is high for exactly 2 cycles, and `calc_reset_n` is low for 2 cycles starting at cycle 1.
- **Two requesters in the same cycle.** Requester 0 sends index 9 and requester 2 sends index 12 → requester 0 gets 34 first, then requester 2 gets 144. `grant_id` reads 0 then 2.
- **Fairness.** All 4 requesters hold `req` continuously with index 1 → grants go 0,1,2,3,0 and no requester is served twice before the others.
- **Out-of-range index.** Index 25 → `rsp_err`=1 and `rsp_data`=0 one cycle after the grant. `calc_reset_n` and `calc_begin` never toggle.
- **Timeout.** Stub `calc_done`=0 with TIMEOUT=16 → `rsp_err`=1 and `rsp_data`=0 after 16 WAIT cycles. The next request is then served normally.
- **Reset mid-job.** Assert `reset_n`=0 during WAIT of an index-12 job → no `rsp_valid` pulse and all outputs are 0 immediately. A re-request after release returns 144.
